// File: rtl/count_seg_scan.sv
// count_seg_scan: 2-digit time-multiplexed 7-segment display stage for the up/down counter.
// It samples the count once per scan frame and shows it in hex or decimal.
// The digits flash while the captured count[5] is set.
//
// Optional feature macro: COUNT_SEG_LZB_EN (leading-zero blanking of the tens digit).
//
// Parameters:
//   SCAN_DIV      clk cycles each digit is lit per frame (>=1)
//   BLINK_FRAMES  frames per blink half-period (>=1)
// Ports:
//   clk    in   system clock, posedge
//   reset  in   synchronous active-low reset
//   count  in   [5:1] counter value; bit 5 = carry/terminal marker
//   hex    in   1: hex display, 0: decimal tens/units
//   seg    out  [7:1] segments a..g, active-low (seg[7]=a)
//   an     out  [2:1] digit enables, active-low; an[1]=units, an[2]=tens
//   frame  out  high for the single BLANK0 (capture) cycle
module count_seg_scan #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:1] count,
    input  logic       hex,
    output logic [7:1] seg,
    output logic [2:1] an,
    output logic       frame
);

    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);
    localparam logic [7:1] SEG_OFF = 7'b1111111;
    localparam logic [2:1] AN_OFF  = 2'b11;
    localparam logic [2:1] AN_UNIT = 2'b10;
    localparam logic [2:1] AN_TENS = 2'b01;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        DIG0   = 2'd1,
        BLANK1 = 2'd2,
        DIG1   = 2'd3
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [5:1]        hold;
    logic              hmode;
    logic [BCNT_W-1:0] bcnt;
    logic              phase;
    // Low for the first cycle after reset release so BLANK0 is visibly entered with frame=1.
    logic              run;

    logic              cap;
    logic [5:1]        hold_n;
    logic              hmode_n;
    logic [BCNT_W-1:0] bcnt_n;
    logic              phase_n;
    logic [4:0]        hv;
    logic [3:0]        units;
    logic [3:0]        tens;
    logic              dark;
    logic [7:1]        seg_unit;
    logic [2:1]        an_unit;
    logic [7:1]        seg_tens;
    logic [2:1]        an_tens;

    // Active-low glyphs {a..g}.
    function automatic logic [7:1] enc(input logic [3:0] d);
        logic [7:1] s;
        case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Values that become current at the next edge; the BLANK0 exit also captures and
    // advances the blink counter, so digit decode must see the post-capture values.
    always_comb begin
        cap     = run && (state == BLANK0);
        hold_n  = hold;
        hmode_n = hmode;
        bcnt_n  = bcnt;
        phase_n = phase;
        if (cap) begin
            hold_n  = count;
            hmode_n = hex;
            if (bcnt == BCNT_LAST) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n = BCNT_W'(bcnt + 1'b1);
            end
        end

        hv = hold_n;
        if (hmode_n) begin
            units = hv[3:0];
            tens  = {3'b000, hv[4]};
        end else begin
            units = 4'(hv % 5'd10);
            tens  = 4'(hv / 5'd10);
        end

        dark = hold_n[5] & phase_n;

        seg_unit = dark ? SEG_OFF : enc(units);
        an_unit  = dark ? AN_OFF  : AN_UNIT;
`ifdef COUNT_SEG_LZB_EN
        seg_tens = (dark || (tens == 4'd0)) ? SEG_OFF : enc(tens);
        an_tens  = (dark || (tens == 4'd0)) ? AN_OFF  : AN_TENS;
`else
        seg_tens = dark ? SEG_OFF : enc(tens);
        an_tens  = dark ? AN_OFF  : AN_TENS;
`endif
    end

    // Scan FSM with registered outputs, loaded on each state transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BLANK0;
            div   <= '0;
            hold  <= '0;
            hmode <= 1'b0;
            bcnt  <= '0;
            phase <= 1'b0;
            run   <= 1'b0;
            an    <= AN_OFF;
            seg   <= SEG_OFF;
            frame <= 1'b0;
        end else if (!run) begin
            run   <= 1'b1;
            frame <= 1'b1;
        end else begin
            case (state)
                BLANK0: begin
                    state <= DIG0;
                    div   <= '0;
                    hold  <= hold_n;
                    hmode <= hmode_n;
                    bcnt  <= bcnt_n;
                    phase <= phase_n;
                    frame <= 1'b0;
                    an    <= an_unit;
                    seg   <= seg_unit;
                end
                DIG0: begin
                    if (div == DIV_LAST) begin
                        state <= BLANK1;
                        div   <= '0;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                    end else begin
                        div <= DIV_W'(div + 1'b1);
                    end
                end
                BLANK1: begin
                    state <= DIG1;
                    div   <= '0;
                    an    <= an_tens;
                    seg   <= seg_tens;
                end
                DIG1: begin
                    if (div == DIV_LAST) begin
                        state <= BLANK0;
                        div   <= '0;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                        frame <= 1'b1;
                    end else begin
                        div <= DIV_W'(div + 1'b1);
                    end
                end
                default: begin
                    state <= BLANK0;
                    div   <= '0;
                end
            endcase
        end
    end

endmodule
